seg_readback: RTL and testbench
===============================

Name: seg_readback

Overview:
- Reader for the calculator's four-digit seven-segment display bus.
- Samples seg1..seg4 and waits until the pattern has been stable for a programmable number of cycles.
- Decodes the stable pattern back to a binary value and delivers it once per distinct stable pattern over a valid/ready handshake.
- Serves as the checking front end for display-level self-test and bench scoreboards of the calculator datapath.

Parameters:
- STABLE_CYCLES, 4: consecutive equal samples required before a pattern counts as settled; legal range 1..255.
- CNT_W, 8: stability counter width; must hold STABLE_CYCLES.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg1  in  7  ones digit; bit0=a ... bit6=g; active-low (0 = segment lit).
- seg2  in  7  tens digit, same encoding.
- seg3  in  7  hundreds digit, same encoding.
- seg4  in  7  thousands digit, same encoding.
- out_ready  in  1  consumer accepts the report.
- out_valid  out  1  report available.
- out_value  out  14  decoded value, 0..9999.
- out_err  out  1  pattern not decodable.
- out_blank  out  1  all four digits blank.
- overrun  out  1  sticky; a stable report was dropped.

Behaviour:
- Reset values, asynchronous: out_valid=0, out_value=0, out_err=0, out_blank=0, overrun=0, seg_q=7'h7F x4, snap=7'h7F x4, cnt=0, have_report=0, state=SETTLE.
- Stage 1: seg_q <= {seg4,seg3,seg2,seg1} every edge.
- Stage 2, stability tracking:
  - If seg_q != snap: snap <= seg_q and cnt <= 0.
  - Otherwise cnt <= cnt+1, saturating at STABLE_CYCLES.
- Settle event: seg_q == snap and cnt == STABLE_CYCLES-1 on the same edge.
  - Fires only if snap != last_reported or have_report == 0.
  - A pattern that disappears and reappears unchanged after the last report is not re-reported.
- Latency: with the pattern constant from the first edge that samples it, out_valid rises after edge STABLE_CYCLES+2 (edge 6 for the default).
- Digit decode, active-low codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); blank=7F.
  - Any other code is invalid.
- Value rules:
  - Blanks are legal only as leading digits, i.e. every more-significant digit is also blank; a leading blank counts as 0.
  - All four blank: out_blank=1, out_value=0, out_err=0.
  - Any invalid code or any non-leading blank: out_err=1, out_value=0.
  - Otherwise out_value = d4*1000 + d3*100 + d2*10 + d1, computed in 14 bits with no overflow possible.
- FSM states and transitions:
  - SETTLE: on a settle event, load out_value, out_err and out_blank, set last_reported <= snap and have_report <= 1, assert out_valid, go to HOLD.
  - HOLD: out_* stay frozen. When out_valid && out_ready, deassert out_valid on that edge and return to SETTLE.
  - A settle event while in HOLD without acceptance: the new pattern is dropped, overrun <= 1, last_reported is not updated.
  - Acceptance and settle event on the same edge: the settle event is taken. out_valid stays high, new data loads, no overrun.
- overrun clears only on reset.
- The stability counter keeps running in HOLD.
- Reset asserted mid-operation: all state returns to reset values immediately; a pending report is lost.

Decomposition:
- Shared package calc_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The ten digit code constants.
  - The digit/width constant DISP_DIGITS = 4.
  - A state enum {SETTLE, HOLD}.
- One sub-module, seg7_digit_decode: combinational 7-bit code -> {valid, blank, digit[3:0]}, instantiated four times.

Test Plan:
- Reset, then seg4..seg1 = 7F,7F,79,78 held 10 cycles, out_ready=1 -> exactly one out_valid pulse, 6 edges after first sample; out_value=17, err=0, blank=0.
- Pattern toggling 12 <-> 13 every 2 cycles for 20 cycles -> no report; then 13 held steady -> single report out_value=13.
- seg2 = 7F with seg3 = 79 (non-leading blank) -> out_err=1, out_value=0; seg1 = 7'h55 in any position -> out_err=1.
- All four 7F -> out_blank=1, out_value=0, out_err=0; 00 00 00 00 -> out_value=8888.
- out_ready=0 with 5 stable, then 9 stable -> first report (5) held, overrun=1, out_value still 5; assert out_ready -> out_valid drops; 9 is not reported until the pattern changes and returns.
- rst_n low mid-settle and while in HOLD -> all outputs 0 asynchronously; after release the stable pattern is reported again after 6 edges.

Source files
------------

// File: rtl/seg_readback_pkg.sv
// Shared constants and types for the calculator seven-segment readback path.
// Segment codes are active-low: bit0=a ... bit6=g, 0 means the segment is lit.
package calc_pkg;

  localparam int DISP_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_D8    = 7'h00;
  localparam logic [6:0] SEG_D9    = 7'h10;

  // SETTLE: watching for a new stable pattern; HOLD: report presented, waiting for acceptance
  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_e;

endpackage

// File: rtl/seg_readback_if.sv
// Display bus plus report handshake for the segment readback block.
// slave is the readback block's view, master is the driver/consumer's view.
interface seg_readback_if;

  logic [6:0]  seg1;
  logic [6:0]  seg2;
  logic [6:0]  seg3;
  logic [6:0]  seg4;
  logic        out_ready;
  logic        out_valid;
  logic [13:0] out_value;
  logic        out_err;
  logic        out_blank;
  logic        overrun;

  modport slave (
    input  seg1, seg2, seg3, seg4, out_ready,
    output out_valid, out_value, out_err, out_blank, overrun
  );

  modport master (
    output seg1, seg2, seg3, seg4, out_ready,
    input  out_valid, out_value, out_err, out_blank, overrun
  );

endinterface

// File: rtl/seg_readback_decode.sv
// Single-digit seven-segment decoder: active-low code -> {valid, blank, digit}.
// A blank code is a legal code (valid=1) reported as digit 0.
module seg7_digit_decode
  import calc_pkg::*;
(
  input  logic [6:0] code_i,
  output logic       valid_o,
  output logic       blank_o,
  output logic [3:0] digit_o
);

  // Map the ten digit codes plus blank; anything else is flagged invalid
  always_comb begin
    valid_o = 1'b1;
    blank_o = 1'b0;
    digit_o = 4'd0;
    case (code_i)
      SEG_D0:    digit_o = 4'd0;
      SEG_D1:    digit_o = 4'd1;
      SEG_D2:    digit_o = 4'd2;
      SEG_D3:    digit_o = 4'd3;
      SEG_D4:    digit_o = 4'd4;
      SEG_D5:    digit_o = 4'd5;
      SEG_D6:    digit_o = 4'd6;
      SEG_D7:    digit_o = 4'd7;
      SEG_D8:    digit_o = 4'd8;
      SEG_D9:    digit_o = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_readback.sv
// Seven-segment display readback: registers the four digit codes, waits until
// the pattern has been stable for STABLE_CYCLES samples, decodes it and offers
// one report per distinct stable pattern over a valid/ready handshake.
module seg_readback
  import calc_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_readback_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE  = CNT_W'(STABLE_CYCLES - 1);

  // Index 0 is the ones digit (seg1), index 3 the thousands digit (seg4)
  logic [DISP_DIGITS-1:0][6:0] seg_q;
  logic [DISP_DIGITS-1:0][6:0] snap_q;
  logic [DISP_DIGITS-1:0][6:0] last_q, last_d;
  logic [CNT_W-1:0]            cnt_q;
  logic                        have_report_q, have_report_d;
  state_e                      state_q, state_d;
  logic [13:0]                 value_q, value_d;
  logic                        err_q, err_d;
  logic                        blank_q, blank_d;
  logic                        overrun_q, overrun_d;

  logic [DISP_DIGITS-1:0]      dig_valid;
  logic [DISP_DIGITS-1:0]      dig_blank;
  logic [DISP_DIGITS-1:0][3:0] dig_val;
  logic                        dec_err;
  logic                        dec_all_blank;
  logic                        above_blank;
  logic [13:0]                 dec_sum;
  logic                        settle;
  logic                        accept;

  // Input sampling stage: one register per digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= {DISP_DIGITS{SEG_BLANK}};
    end else begin
      seg_q <= {bus.seg4, bus.seg3, bus.seg2, bus.seg1};
    end
  end

  // Stability tracking: restart on any change, otherwise count up and saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= {DISP_DIGITS{SEG_BLANK}};
      cnt_q  <= '0;
    end else if (seg_q != snap_q) begin
      snap_q <= seg_q;
      cnt_q  <= '0;
    end else if (cnt_q != CNT_LIMIT) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Decode the settled snapshot one digit at a time
  for (genvar gi = 0; gi < DISP_DIGITS; gi++) begin : g_dec
    seg7_digit_decode u_dec (
      .code_i  (snap_q[gi]),
      .valid_o (dig_valid[gi]),
      .blank_o (dig_blank[gi]),
      .digit_o (dig_val[gi])
    );
  end

  // Walk from the most significant digit: a blank is only legal while every digit above it is blank
  always_comb begin
    above_blank = 1'b1;
    dec_err     = 1'b0;
    for (int i = DISP_DIGITS - 1; i >= 0; i--) begin
      if (!dig_valid[i]) dec_err = 1'b1;
      if (dig_blank[i] && !above_blank) dec_err = 1'b1;
      above_blank = above_blank & dig_blank[i];
    end
    dec_all_blank = above_blank;
    // Blank digits decode as 0, so leading blanks contribute nothing
    dec_sum = 14'(dig_val[3]) * 14'd1000 + 14'(dig_val[2]) * 14'd100
            + 14'(dig_val[1]) * 14'd10   + 14'(dig_val[0]);
  end

  // A settle event only counts for a pattern that differs from the last one reported
  assign settle = (seg_q == snap_q) && (cnt_q == CNT_FIRE)
               && (!have_report_q || (snap_q != last_q));
  assign accept = (state_q == HOLD) && bus.out_ready;

  // Report FSM next-state: load on settle, freeze in HOLD, flag dropped patterns
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    err_d         = err_q;
    blank_d       = blank_q;
    last_d        = last_q;
    have_report_d = have_report_q;
    overrun_d     = overrun_q;
    case (state_q)
      SETTLE: begin
        if (settle) begin
          value_d       = dec_err ? 14'd0 : dec_sum;
          err_d         = dec_err;
          blank_d       = dec_all_blank && !dec_err;
          last_d        = snap_q;
          have_report_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (settle && accept) begin
          // Consumer takes the old report on the same edge the new one loads
          value_d       = dec_err ? 14'd0 : dec_sum;
          err_d         = dec_err;
          blank_d       = dec_all_blank && !dec_err;
          last_d        = snap_q;
          have_report_d = 1'b1;
        end else if (settle) begin
          overrun_d = 1'b1;
        end else if (accept) begin
          state_d = SETTLE;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  // Report FSM state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SETTLE;
      value_q       <= '0;
      err_q         <= 1'b0;
      blank_q       <= 1'b0;
      last_q        <= {DISP_DIGITS{SEG_BLANK}};
      have_report_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      err_q         <= err_d;
      blank_q       <= blank_d;
      last_q        <= last_d;
      have_report_q <= have_report_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_value = value_q;
  assign bus.out_err   = err_q;
  assign bus.out_blank = blank_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg_readback.sv
// Scoreboard bench for seg_readback: stimulus pushes expected reports,
// the monitor pops one per accepted handshake.
module tb_seg_readback;

  logic clk;
  logic rst_n;

  seg_readback_if bus ();

  seg_readback #(
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int v;
    int e;
    int b;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic set_pat(input logic [6:0] d4, input logic [6:0] d3,
                         input logic [6:0] d2, input logic [6:0] d1);
    bus.seg4 = d4;
    bus.seg3 = d3;
    bus.seg2 = d2;
    bus.seg1 = d1;
  endtask

  task automatic push(input int v, input int e, input int b);
    exp_t x;
    x.v = v;
    x.e = e;
    x.b = b;
    sb_q.push_back(x);
  endtask

  // Advance n rising edges and settle 2 time units past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called 2 units after a reset release with the pattern already applied
  task automatic latency(input string nm);
    repeat (5) @(posedge clk);
    #1;
    chk({nm, "_edge5_valid"}, int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk({nm, "_edge6_valid"}, int'(bus.out_valid), 1);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"},   int'(bus.out_valid), 0);
    chk({nm, "_value"},   int'(bus.out_value), 0);
    chk({nm, "_err"},     int'(bus.out_err),   0);
    chk({nm, "_blank"},   int'(bus.out_blank), 0);
    chk({nm, "_overrun"}, int'(bus.overrun),   0);
  endtask

  // Monitor: a report transfers on the next rising edge when valid and ready are both high
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      $display("report value=%0d err=%0d blank=%0d t=%0t",
               bus.out_value, bus.out_err, bus.out_blank, $time);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_report actual_value=%0d required=no_report", bus.out_value);
      end else begin
        mon_e = sb_q.pop_front();
        chk("report_value", int'(bus.out_value), mon_e.v);
        chk("report_err",   int'(bus.out_err),   mon_e.e);
        chk("report_blank", int'(bus.out_blank), mon_e.b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    set_pat(7'h7F, 7'h7F, 7'h79, 7'h78);   // "  17"
    #12;
    chk_reset_outputs("reset");

    // 17: single report, 6 edges after the first sample
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push(17, 0, 0);
    latency("lat17");
    tick(4);

    // 12 <-> 13 toggling never settles, then 13 held reports once
    for (int k = 0; k < 5; k++) begin
      set_pat(7'h7F, 7'h7F, 7'h79, 7'h24);
      tick(2);
      set_pat(7'h7F, 7'h7F, 7'h79, 7'h30);
      tick(2);
    end
    chk("toggle_no_valid", int'(bus.out_valid), 0);
    push(13, 0, 0);
    tick(10);

    // Non-leading blank in tens position
    push(0, 1, 0);
    set_pat(7'h7F, 7'h79, 7'h7F, 7'h40);
    tick(10);
    // Undefined code in ones position
    push(0, 1, 0);
    set_pat(7'h7F, 7'h7F, 7'h79, 7'h55);
    tick(10);
    // Undefined code in thousands position
    push(0, 1, 0);
    set_pat(7'h55, 7'h40, 7'h40, 7'h40);
    tick(10);

    // All blank, all eights, all nines, all zeros
    push(0, 0, 1);
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    tick(10);
    push(8888, 0, 0);
    set_pat(7'h00, 7'h00, 7'h00, 7'h00);
    tick(10);
    push(9999, 0, 0);
    set_pat(7'h10, 7'h10, 7'h10, 7'h10);
    tick(10);
    push(0, 0, 0);
    set_pat(7'h40, 7'h40, 7'h40, 7'h40);
    tick(10);

    // Back-pressure: 5 held, 9 dropped with overrun
    bus.out_ready = 1'b0;
    push(5, 0, 0);
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'h12);
    tick(10);
    chk("hold5_valid",   int'(bus.out_valid), 1);
    chk("hold5_value",   int'(bus.out_value), 5);
    chk("hold5_overrun", int'(bus.overrun),   0);
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'h10);
    tick(10);
    chk("drop9_overrun", int'(bus.overrun),   1);
    chk("drop9_valid",   int'(bus.out_valid), 1);
    chk("drop9_value",   int'(bus.out_value), 5);
    bus.out_ready = 1'b1;
    tick(3);
    chk("accept5_valid_low", int'(bus.out_valid), 0);
    tick(10);
    chk("no_report_9_valid", int'(bus.out_valid), 0);
    chk("overrun_sticky",    int'(bus.overrun),   1);
    // 9 returns after a short glitch and is now reported
    set_pat(7'h00, 7'h00, 7'h00, 7'h00);
    tick(2);
    push(9, 0, 0);
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'h10);
    tick(10);
    // Same glitch again: 9 was the last report, so nothing new
    set_pat(7'h00, 7'h00, 7'h00, 7'h00);
    tick(2);
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'h10);
    tick(10);
    chk("rereport_9_valid", int'(bus.out_valid), 0);

    // Reset mid-settle clears everything including overrun
    set_pat(7'h7F, 7'h7F, 7'h79, 7'h78);
    tick(3);
    #4;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_settle");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push(17, 0, 0);
    latency("lat_rst_settle");
    tick(4);

    // Reset while a report is held loses it; pattern is reported again after release
    bus.out_ready = 1'b0;
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'h12);
    tick(10);
    chk("hold_pre_rst_valid", int'(bus.out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_hold");
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    push(5, 0, 0);
    latency("lat_rst_hold");
    tick(4);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
